ila_trig_capture: RTL and testbench

//  Parametrised integrated logic analyser core: continuously samples data_in into a circular

---
 rtl/ila_pkg.sv | 20 ++
 rtl/ila_trig_capture_if.sv | 30 +++
 rtl/ila_sample_ram.sv | 20 ++
 rtl/ila_trig_capture.sv | 167 ++++++++++++++++
 tb/tb_ila_trig_capture.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ila_pkg.sv
// ila_pkg: shared trigger-mode and state encodings plus buffer depth derivation
package ila_pkg;
  typedef enum logic [1:0] {
    TM_MATCH    = 2'b00,
    TM_MISMATCH = 2'b01,
    TM_RISE     = 2'b10,
    TM_IMM      = 2'b11
  } trig_mode_e;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_WAIT,
    ST_POST,
    ST_DONE,
    ST_READ
  } ila_state_e;
  function automatic int ila_depth(input int aw);
    return 1 << aw;
  endfunction
endpackage

// File: rtl/ila_trig_capture_if.sv
// ila_trig_capture_if: control, config, status and readout stream of the logic analyser
interface ila_trig_capture_if #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 8
);
  logic                  arm;
  logic                  abort;
  logic [DATA_WIDTH-1:0] data_in;
  logic [DATA_WIDTH-1:0] trig_value;
  logic [DATA_WIDTH-1:0] trig_mask;
  logic [1:0]            trig_mode;
  logic [ADDR_WIDTH-1:0] pretrig_len;
  logic                  armed;
  logic                  triggered;
  logic                  done;
  logic [ADDR_WIDTH-1:0] trig_addr;
  logic                  rd_start;
  logic                  rd_valid;
  logic                  rd_ready;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_last;
  modport master (
    output arm, abort, data_in, trig_value, trig_mask, trig_mode, pretrig_len, rd_start, rd_ready,
    input  armed, triggered, done, trig_addr, rd_valid, rd_data, rd_last
  );
  modport slave (
    input  arm, abort, data_in, trig_value, trig_mask, trig_mode, pretrig_len, rd_start, rd_ready,
    output armed, triggered, done, trig_addr, rd_valid, rd_data, rd_last
  );
endinterface

// File: rtl/ila_sample_ram.sv
// ila_sample_ram: simple dual-port sample RAM, sync write, registered read with enable
module ila_sample_ram #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  // write port and one-cycle registered read port
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/ila_trig_capture.sv
// ila_trig_capture: armed circular capture with programmable trigger, pre-trigger window and skid readout
module ila_trig_capture
  import ila_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 8
) (
  input logic clk,
  input logic rst,
  ila_trig_capture_if.slave bus
);
  localparam int DEPTH = ila_depth(ADDR_WIDTH);
  typedef logic [ADDR_WIDTH-1:0] addr_t;
  typedef logic [ADDR_WIDTH:0]   cnt_t;
  typedef logic [DATA_WIDTH-1:0] data_t;
  ila_state_e state_q, state_d;
  trig_mode_e mode_q, mode_d;
  addr_t wr_ptr_q, wr_ptr_d, pre_cnt_q, pre_cnt_d, post_cnt_q, post_cnt_d;
  addr_t rd_ptr_q, rd_ptr_d, pre_q, pre_d, trig_addr_q, trig_addr_d;
  cnt_t  iss_cnt_q, iss_cnt_d;
  data_t tv_q, tv_d, tm_q, tm_d, prev_q, prev_d, buf0_q, buf0_d, buf1_q, buf1_d;
  logic  armed_q, armed_d, triggered_q, triggered_d, done_q, done_d;
  logic  ram_vld_q, ram_vld_d, ram_last_q, ram_last_d;
  logic  last0_q, last0_d, last1_q, last1_d;
  logic [1:0] occ_q, occ_d, occ_nx;
  logic  sampling, hit, push, pop, start_rd, issue;
  data_t masked, rdata;
  addr_t raddr;
  assign sampling = state_q inside {ST_FILL, ST_WAIT, ST_POST};
  assign masked   = (bus.data_in ^ tv_q) & tm_q;
  assign hit      = mode_q == TM_MATCH    ? masked == '0 :
                    mode_q == TM_MISMATCH ? masked != '0 :
                    mode_q == TM_RISE     ? |(bus.data_in & ~prev_q & tm_q) : 1'b1;
  assign push     = ram_vld_q;
  assign pop      = occ_q != 2'd0 && bus.rd_ready;
  assign occ_nx   = occ_q + 2'(push) - 2'(pop);
  // the first read is issued in the rd_start cycle so data appears two cycles later
  assign start_rd = state_q == ST_DONE && bus.rd_start && !bus.arm && !bus.abort;
  assign issue    = start_rd || (state_q == ST_READ && !iss_cnt_q[ADDR_WIDTH] && occ_nx <= 2'd1);
  assign raddr    = start_rd ? trig_addr_q - pre_q : rd_ptr_q;
  ila_sample_ram #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_ram (
    .clk   (clk),
    .we    (sampling),
    .waddr (wr_ptr_q),
    .wdata (bus.data_in),
    .re    (issue),
    .raddr (raddr),
    .rdata (rdata)
  );
  // capture FSM, trigger, counters and two-entry skid buffer next-state
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    tv_d        = tv_q;
    tm_d        = tm_q;
    pre_d       = pre_q;
    pre_cnt_d   = pre_cnt_q;
    post_cnt_d  = post_cnt_q;
    trig_addr_d = trig_addr_q;
    triggered_d = triggered_q;
    wr_ptr_d    = sampling ? wr_ptr_q + 1'b1 : wr_ptr_q;
    prev_d      = sampling ? bus.data_in : prev_q;
    rd_ptr_d    = issue ? raddr + 1'b1 : rd_ptr_q;
    iss_cnt_d   = start_rd ? cnt_t'(1) : iss_cnt_q + cnt_t'(issue);
    ram_vld_d   = issue && !bus.abort;
    ram_last_d  = !start_rd && iss_cnt_q == cnt_t'(DEPTH - 1);
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.arm) begin
          state_d     = ST_FILL;
          mode_d      = trig_mode_e'(bus.trig_mode);
          tv_d        = bus.trig_value;
          tm_d        = bus.trig_mask;
          pre_d       = bus.pretrig_len;
          pre_cnt_d   = '0;
          triggered_d = 1'b0;
        end else if (start_rd) state_d = ST_READ;
      end
      ST_FILL: begin
        if (pre_cnt_q == pre_q) state_d = ST_WAIT;
        else pre_cnt_d = pre_cnt_q + 1'b1;
      end
      ST_WAIT: begin
        if (hit) begin
          trig_addr_d = wr_ptr_q;
          triggered_d = 1'b1;
          post_cnt_d  = addr_t'(DEPTH - 1) - pre_q;
          state_d     = &pre_q ? ST_DONE : ST_POST;
        end
      end
      ST_POST: begin
        post_cnt_d = post_cnt_q - 1'b1;
        if (post_cnt_q == addr_t'(1)) state_d = ST_DONE;
      end
      ST_READ: if (pop && last0_q) state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase
    if (bus.abort) begin
      state_d     = ST_IDLE;
      triggered_d = 1'b0;
    end
    buf0_d  = pop && occ_q == 2'd2 ? buf1_q : push && (occ_q == 2'd0 || (pop && occ_q == 2'd1)) ? rdata : buf0_q;
    last0_d = pop && occ_q == 2'd2 ? last1_q : push && (occ_q == 2'd0 || (pop && occ_q == 2'd1)) ? ram_last_q : last0_q;
    buf1_d  = push && (occ_q == 2'd2 ? pop : occ_q == 2'd1 && !pop) ? rdata : buf1_q;
    last1_d = push && (occ_q == 2'd2 ? pop : occ_q == 2'd1 && !pop) ? ram_last_q : last1_q;
    occ_d   = bus.abort ? 2'd0 : occ_nx;
    armed_d = state_d inside {ST_FILL, ST_WAIT, ST_POST};
    done_d  = state_d == ST_DONE;
  end
  // state and registered outputs, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      mode_q      <= TM_MATCH;
      tv_q        <= '0;
      tm_q        <= '0;
      pre_q       <= '0;
      pre_cnt_q   <= '0;
      post_cnt_q  <= '0;
      trig_addr_q <= '0;
      triggered_q <= 1'b0;
      wr_ptr_q    <= '0;
      prev_q      <= '0;
      rd_ptr_q    <= '0;
      iss_cnt_q   <= '0;
      ram_vld_q   <= 1'b0;
      ram_last_q  <= 1'b0;
      buf0_q      <= '0;
      buf1_q      <= '0;
      last0_q     <= 1'b0;
      last1_q     <= 1'b0;
      occ_q       <= 2'd0;
      armed_q     <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      tv_q        <= tv_d;
      tm_q        <= tm_d;
      pre_q       <= pre_d;
      pre_cnt_q   <= pre_cnt_d;
      post_cnt_q  <= post_cnt_d;
      trig_addr_q <= trig_addr_d;
      triggered_q <= triggered_d;
      wr_ptr_q    <= wr_ptr_d;
      prev_q      <= prev_d;
      rd_ptr_q    <= rd_ptr_d;
      iss_cnt_q   <= iss_cnt_d;
      ram_vld_q   <= ram_vld_d;
      ram_last_q  <= ram_last_d;
      buf0_q      <= buf0_d;
      buf1_q      <= buf1_d;
      last0_q     <= last0_d;
      last1_q     <= last1_d;
      occ_q       <= occ_d;
      armed_q     <= armed_d;
      done_q      <= done_d;
    end
  end
  assign bus.armed     = armed_q;
  assign bus.triggered = triggered_q;
  assign bus.done      = done_q;
  assign bus.trig_addr = trig_addr_q;
  assign bus.rd_valid  = occ_q != 2'd0;
  assign bus.rd_data   = buf0_q;
  assign bus.rd_last   = last0_q && occ_q != 2'd0;
endmodule

// File: tb/tb_ila_trig_capture.sv
// tb_ila_trig_capture: directed scenario tests of the logic analyser core
module tb_ila_trig_capture;
  logic clk = 1'b0;
  logic rst = 1'b1;
  bit   inc = 1'b1;
  int   total = 0;
  int   bad = 0;
  ila_trig_capture_if #(.DATA_WIDTH(16), .ADDR_WIDTH(4)) bus ();
  ila_trig_capture #(.DATA_WIDTH(16), .ADDR_WIDTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );
  always #5 clk = ~clk;
  task automatic cyc();
    @(posedge clk);
    #1;
    bus.arm = 1'b0;
    bus.abort = 1'b0;
    bus.rd_start = 1'b0;
    if (inc) bus.data_in = bus.data_in + 16'd1;
  endtask
  task automatic capture(input logic [15:0] d0, input logic [1:0] mode, input logic [15:0] val,
                         input logic [15:0] mask, input logic [3:0] pre);
    bus.data_in = d0;
    bus.trig_mode = mode;
    bus.trig_value = val;
    bus.trig_mask = mask;
    bus.pretrig_len = pre;
    bus.arm = 1'b1;
    cyc();
  endtask
  task automatic wait_done(input string name);
    int n = 0;
    while (!bus.done && n < 300) begin
      cyc();
      n++;
    end
    total++;
    if (bus.done !== 1'b1) begin
      bad++;
      $display("FAIL %s done timeout: got done=%b want 1", name, bus.done);
    end
  endtask
  task automatic read_window(input bit bp, output logic [15:0] beats [16], output logic [15:0] lasts,
                             output int nb, output int fv, output int stab_err);
    logic [15:0] hold = '0;
    logic stalled = 1'b0;
    nb = 0;
    fv = -1;
    lasts = '0;
    stab_err = 0;
    for (int i = 0; i < 16; i++) beats[i] = '0;
    bus.rd_ready = 1'b1;
    bus.rd_start = 1'b1;
    cyc();
    for (int k = 0; k < 100 && nb < 16; k++) begin
      bus.rd_ready = bp ? k[0] : 1'b1;
      if (bus.rd_valid && fv < 0) fv = k;
      if (stalled && (!bus.rd_valid || bus.rd_data !== hold)) stab_err++;
      if (bus.rd_valid && bus.rd_ready) begin
        beats[nb] = bus.rd_data;
        lasts[nb] = bus.rd_last;
        nb++;
      end
      stalled = bus.rd_valid && !bus.rd_ready;
      hold = bus.rd_data;
      cyc();
    end
    bus.rd_ready = 1'b1;
  endtask
  task automatic check_window(input string name, input bit bp, input logic [15:0] base);
    logic [15:0] beats [16];
    logic [15:0] lasts;
    int nb, fv, se, wrong;
    read_window(bp, beats, lasts, nb, fv, se);
    wrong = 0;
    for (int i = 0; i < 16; i++) if (beats[i] !== base + 16'(i)) wrong++;
    total++;
    if (nb !== 16 || wrong !== 0) begin
      bad++;
      $display("FAIL %s window: got %0d beats, %0d wrong, first=%h; want 16 beats from %h", name, nb, wrong, beats[0], base);
    end
    total++;
    if (lasts !== 16'h8000) begin
      bad++;
      $display("FAIL %s rd_last: got %h want 8000", name, lasts);
    end
    total++;
    if (fv !== 1) begin
      bad++;
      $display("FAIL %s first rd_valid latency: got %0d want 1", name, fv);
    end
    total++;
    if (se !== 0) begin
      bad++;
      $display("FAIL %s stall stability: got %0d changes want 0", name, se);
    end
    total++;
    if (bus.rd_valid !== 1'b0 || bus.done !== 1'b1) begin
      bad++;
      $display("FAIL %s after readout: got rd_valid=%b done=%b want 0 1", name, bus.rd_valid, bus.done);
    end
  endtask
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) cyc();
    total++;
    if ({bus.armed, bus.triggered, bus.done, bus.rd_valid, bus.rd_last, bus.trig_addr, bus.rd_data} !== '0) begin
      bad++;
      $display("FAIL reset outputs: got armed=%b trig=%b done=%b rd_valid=%b addr=%h data=%h want all 0",
               bus.armed, bus.triggered, bus.done, bus.rd_valid, bus.trig_addr, bus.rd_data);
    end
    rst = 1'b0;
    cyc();
  endtask
  task automatic test_match();
    capture(16'h0050, 2'b00, 16'h0064, 16'hFFFF, 4'd4);
    total++;
    if (bus.armed !== 1'b1 || bus.done !== 1'b0) begin
      bad++;
      $display("FAIL match armed: got armed=%b done=%b want 1 0", bus.armed, bus.done);
    end
    wait_done("match");
    total++;
    if (bus.triggered !== 1'b1 || bus.trig_addr !== 4'd3 || bus.armed !== 1'b0) begin
      bad++;
      $display("FAIL match trig status: got triggered=%b trig_addr=%h armed=%b want 1 3 0",
               bus.triggered, bus.trig_addr, bus.armed);
    end
    check_window("match", 1'b0, 16'h0060);
    check_window("match replay", 1'b0, 16'h0060);
  endtask
  task automatic test_config_isolation();
    capture(16'h0100, 2'b00, 16'h0110, 16'hFFFF, 4'd2);
    bus.trig_value = 16'h0105;
    wait_done("cfg");
    check_window("cfg", 1'b0, 16'h010E);
  endtask
  task automatic test_wrap_backpressure();
    capture(16'h0200, 2'b00, 16'h0230, 16'hFFFF, 4'd15);
    wait_done("wrap");
    check_window("wrap", 1'b1, 16'h0221);
  endtask
  task automatic test_immediate();
    capture(16'h0300, 2'b11, 16'h0000, 16'hFFFF, 4'd0);
    wait_done("imm");
    check_window("imm", 1'b0, 16'h0302);
  endtask
  task automatic test_edge();
    logic [15:0] beats [16];
    logic [15:0] lasts;
    int nb, fv, se, wrong;
    inc = 1'b0;
    capture(16'h0000, 2'b10, 16'h0000, 16'h0008, 4'd2);
    repeat (6) cyc();
    total++;
    if (bus.triggered !== 1'b0 || bus.armed !== 1'b1) begin
      bad++;
      $display("FAIL edge pre-rise: got triggered=%b armed=%b want 0 1", bus.triggered, bus.armed);
    end
    bus.data_in = 16'h0008;
    cyc();
    total++;
    if (bus.triggered !== 1'b1) begin
      bad++;
      $display("FAIL edge rise: got triggered=%b want 1", bus.triggered);
    end
    wait_done("edge");
    read_window(1'b0, beats, lasts, nb, fv, se);
    wrong = 0;
    for (int i = 0; i < 16; i++) if (beats[i] !== (i < 2 ? 16'h0000 : 16'h0008)) wrong++;
    total++;
    if (nb !== 16 || wrong !== 0) begin
      bad++;
      $display("FAIL edge window: got %0d beats, %0d wrong want 16 beats 0,0,8..", nb, wrong);
    end
    capture(16'h0008, 2'b10, 16'h0000, 16'h0008, 4'd2);
    repeat (40) cyc();
    total++;
    if (bus.triggered !== 1'b0 || bus.armed !== 1'b1) begin
      bad++;
      $display("FAIL edge already-high: got triggered=%b armed=%b want 0 1", bus.triggered, bus.armed);
    end
    bus.abort = 1'b1;
    cyc();
    inc = 1'b1;
  endtask
  task automatic test_abort_reset();
    int n = 0;
    capture(16'h0400, 2'b00, 16'h0410, 16'hFFFF, 4'd4);
    while (!bus.triggered && n < 60) begin
      cyc();
      n++;
    end
    total++;
    if (bus.triggered !== 1'b1 || bus.armed !== 1'b1) begin
      bad++;
      $display("FAIL abort reach POST: got triggered=%b armed=%b want 1 1", bus.triggered, bus.armed);
    end
    bus.abort = 1'b1;
    cyc();
    total++;
    if ({bus.armed, bus.triggered, bus.done, bus.rd_valid} !== 4'b0000) begin
      bad++;
      $display("FAIL abort outputs: got %b want 0000", {bus.armed, bus.triggered, bus.done, bus.rd_valid});
    end
    bus.rd_start = 1'b1;
    cyc();
    cyc();
    total++;
    if (bus.rd_valid !== 1'b0 || bus.done !== 1'b0) begin
      bad++;
      $display("FAIL abort rd_start ignored: got rd_valid=%b done=%b want 0 0", bus.rd_valid, bus.done);
    end
    capture(16'h0500, 2'b11, 16'h0000, 16'hFFFF, 4'd0);
    wait_done("rst");
    bus.rd_ready = 1'b1;
    bus.rd_start = 1'b1;
    repeat (4) cyc();
    total++;
    if (bus.rd_valid !== 1'b1) begin
      bad++;
      $display("FAIL rst mid-read streaming: got rd_valid=%b want 1", bus.rd_valid);
    end
    #2;
    rst = 1'b1;
    #1;
    total++;
    if ({bus.armed, bus.triggered, bus.done, bus.rd_valid, bus.rd_last, bus.trig_addr, bus.rd_data} !== '0) begin
      bad++;
      $display("FAIL async rst: got armed=%b trig=%b done=%b rd_valid=%b addr=%h data=%h want all 0",
               bus.armed, bus.triggered, bus.done, bus.rd_valid, bus.trig_addr, bus.rd_data);
    end
    cyc();
    rst = 1'b0;
    cyc();
  endtask
  initial begin
    bus.arm = 1'b0;
    bus.abort = 1'b0;
    bus.data_in = '0;
    bus.trig_value = '0;
    bus.trig_mask = '0;
    bus.trig_mode = 2'b00;
    bus.pretrig_len = '0;
    bus.rd_start = 1'b0;
    bus.rd_ready = 1'b1;
    test_reset();
    test_match();
    test_config_isolation();
    test_wrap_backpressure();
    test_immediate();
    test_edge();
    test_abort_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
